// File: rtl/norm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : norm_pkg                                                       |
// | Purpose   : Shared definitions for the L1 normalization sequencer:         |
// |             FSM state encoding (3 bits), default geometry of the norm      |
// |             unit and a saturating increment helper for the perf counters.  |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package norm_pkg;

  // Norm-unit row FIFO depth; also the largest legal pass length.
  localparam int NORM_DEPTH     = 16;
  // Row counter width; must be able to hold the value NORM_DEPTH itself.
  localparam int NORM_CNTW      = 5;
  // Columns per psum row (width of the norm-unit write strobe bus).
  localparam int NORM_COL       = 8;
  // Cycles from the last acc to the first legal div (sum_q reg + fifo_wr reg).
  localparam int NORM_DRAIN_CYC = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACC     = 3'd1,
    S_DRAIN   = 3'd2,
    S_DIV     = 3'd3,
    S_WAIT_WR = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage : norm_pkg
`default_nettype wire

// File: rtl/norm_row_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : norm_row_cnt                                                   |
// | Purpose   : CNTW-bit row up-counter with synchronous clear, increment      |
// |             enable and a terminal-value compare.                           |
// | Ports     : clk     in   clock                                             |
// |             rst_n   in   asynchronous active-low reset                     |
// |             i_clr   in   clear to zero (has priority over i_inc)           |
// |             i_inc   in   count up by one                                   |
// |             i_term  in   terminal value for o_hit                          |
// |             o_cnt   out  current count                                     |
// |             o_hit   out  current count equals i_term                       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module norm_row_cnt #(
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_inc,
  input  logic [CNTW-1:0] i_term,
  output logic [CNTW-1:0] o_cnt,
  output logic            o_hit
);

  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = (r_cnt == i_term);

endmodule : norm_row_cnt
`default_nettype wire

// File: rtl/norm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : norm_seq_ctrl                                                  |
// | Purpose   : Sequencer for the single-core L1 normalization unit. Accepts N |
// |             psum rows and drives acc one row per cycle, waits for the sum  |
// |             FIFO write to land, drives div under downstream back-pressure, |
// |             counts norm_wr returns and pulses done.                        |
// | Config    : NORM_SEQ_CTRL_PERF_EN - adds perf_cycles / perf_stall outputs  |
// |             (saturating, cleared on start, held after done).               |
// | Ports     : clk         in   clock                                         |
// |             reset       in   asynchronous active-low reset                 |
// |             start       in   1-cycle pulse in IDLE, latches num_rows       |
// |             num_rows    in   rows in this pass, legal 1..DEPTH             |
// |             in_valid    in   upstream psum row valid                       |
// |             in_ready    out  row accepted (high only in ACC)              |
// |             acc         out  in_valid & in_ready                          |
// |             div         out  pop and divide one row                       |
// |             out_ready   in   downstream can take a normalized row         |
// |             norm_wr_in  in   norm-unit write strobes (all-ones = 1 write)  |
// |             busy        out  any state except IDLE                        |
// |             done        out  1-cycle pulse at pass completion             |
// |             err         out  1-cycle pulse, registered (one cycle after    |
// |                              the offending start/strobe)                   |
// |             perf_cycles out  [PERF_EN] cycles spent busy                  |
// |             perf_stall  out  [PERF_EN] ACC&!in_valid + DIV&!out_ready     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module norm_seq_ctrl
  import norm_pkg::*;
#(
  parameter int COL       = NORM_COL,
  parameter int DEPTH     = NORM_DEPTH,
  parameter int CNTW      = NORM_CNTW,
  parameter int DRAIN_CYC = NORM_DRAIN_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [CNTW-1:0] num_rows,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            acc,
  output logic            div,
  input  logic            out_ready,
  input  logic [COL-1:0]  norm_wr_in,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef NORM_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]     perf_cycles,
  output logic [15:0]     perf_stall
`endif
);

  // Drain counter only has to reach DRAIN_CYC-1.
  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  state_t          r_state;
  state_t          w_next;

  logic [CNTW-1:0] r_num;        // latched pass length N
  logic [DW-1:0]   r_dcnt;
  logic            r_err;

  logic            w_in_ready;
  logic            w_acc;
  logic            w_div;
  logic            w_done;
  logic            w_start_ok;
  logic            w_illegal;

  logic [CNTW-1:0] w_last_idx;   // N-1
  logic            w_rows_ok;
  logic            w_drain_last;

  logic [CNTW-1:0] w_acc_cnt_unused;
  logic [CNTW-1:0] w_div_cnt;
  logic [CNTW-1:0] w_wr_cnt;
  logic            w_acc_hit;
  logic            w_div_hit;
  logic            w_wr_hit;
  logic            w_wr_all;

  logic            w_wr_full;
  logic            w_wr_partial;
  logic            w_outstanding;
  logic            w_wr_ok;

  // --------------------------------------------------------------------------
  // Pass length and strobe qualification
  // --------------------------------------------------------------------------
  assign w_rows_ok  = (num_rows != '0) && (num_rows <= CNTW'(DEPTH));
  assign w_last_idx = r_num - CNTW'(1);

  assign w_wr_full     = &norm_wr_in;
  assign w_wr_partial  = (|norm_wr_in) && !w_wr_full;
  // A write return is only legitimate while a div is still unanswered.
  assign w_outstanding = (w_div_cnt != w_wr_cnt);
  assign w_wr_ok       = w_wr_full && w_outstanding;
  assign w_wr_all      = (w_wr_cnt == r_num);

  // --------------------------------------------------------------------------
  // Row counters
  // --------------------------------------------------------------------------
  // acc progress only needs the terminal compare, the running value is unused.
  norm_row_cnt #(.CNTW(CNTW)) u_acc_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_start_ok),
    .i_inc  (w_acc),
    .i_term (w_last_idx),
    .o_cnt  (w_acc_cnt_unused),
    .o_hit  (w_acc_hit)
  );

  norm_row_cnt #(.CNTW(CNTW)) u_div_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_start_ok),
    .i_inc  (w_div),
    .i_term (w_last_idx),
    .o_cnt  (w_div_cnt),
    .o_hit  (w_div_hit)
  );

  // Returns are only possible after a div, so gating on outstanding work is
  // enough to keep this counter idle before and during ACC.
  norm_row_cnt #(.CNTW(CNTW)) u_wr_cnt (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (w_start_ok),
    .i_inc  (w_wr_ok),
    .i_term (w_last_idx),
    .o_cnt  (w_wr_cnt),
    .o_hit  (w_wr_hit)
  );

  // --------------------------------------------------------------------------
  // Pass length latch and drain timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num <= '0;
    end else if (w_start_ok) begin
      r_num <= num_rows;
    end
  end

  assign w_drain_last = (r_dcnt == DW'(DRAIN_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dcnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_dcnt <= r_dcnt + DW'(1);
    end else begin
      r_dcnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_acc      = 1'b0;
    w_div      = 1'b0;
    w_done     = 1'b0;
    w_start_ok = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_rows_ok) begin
            w_start_ok = 1'b1;
            w_next     = S_ACC;
          end else begin
            w_illegal  = 1'b1;
          end
        end
      end
      S_ACC: begin
        w_in_ready = 1'b1;
        w_acc      = in_valid;
        if (in_valid && w_acc_hit) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_next = S_DIV;
        end
      end
      S_DIV: begin
        w_div = out_ready;
        if (out_ready && w_div_hit) begin
          w_next = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        // Look ahead by one return so done lands the cycle after the last
        // strobe rather than one cycle later.
        if (w_wr_all || (w_wr_hit && w_wr_ok)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Error pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal || w_wr_partial || (w_wr_full && !w_outstanding);
    end
  end

  assign in_ready = w_in_ready;
  assign acc      = w_acc;
  assign div      = w_div;
  assign done     = w_done;
  assign busy     = (r_state != S_IDLE);
  assign err      = r_err;

`ifdef NORM_SEQ_CTRL_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  logic [15:0] r_perf_cycles;
  logic [15:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = ((r_state == S_ACC) && !in_valid) ||
                   ((r_state == S_DIV) && !out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_start_ok) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy) begin
        r_perf_cycles <= sat_inc16(r_perf_cycles);
      end
      if (w_stall) begin
        r_perf_stall <= sat_inc16(r_perf_stall);
      end
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`endif

endmodule : norm_seq_ctrl
`default_nettype wire

// File: tb/tb_norm_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_norm_seq_ctrl                                               |
// | Purpose   : Directed self-checking bench for norm_seq_ctrl. Each pass is   |
// |             started at a known cycle s; a negedge monitor records event    |
// |             cycles relative to s, which are compared against hand-derived  |
// |             values. Write strobes are returned one cycle after each div.   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_norm_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [4:0] num_rows = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] norm_wr_in = '0;
  logic       in_ready, acc, div, busy, done, err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s = 0;
  bit mon_on = 1'b0;

  int acc_n, div_n, both_n, err_n, done_n, busy_n, rdy_n, div_nrdy_n;
  int first_acc, last_acc, first_div, done_rel;
  bit last_div = 1'b0;

  norm_seq_ctrl u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rows   (num_rows),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc        (acc),
    .div        (div),
    .out_ready  (out_ready),
    .norm_wr_in (norm_wr_in),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, records event counts and cycles relative to s.
  always @(negedge clk) begin
    last_div = div;
    if (mon_on) begin
      if (acc) begin
        acc_n++;
        if (first_acc < 0) first_acc = cyc - s;
        last_acc = cyc - s;
      end
      if (div) begin
        div_n++;
        if (first_div < 0) first_div = cyc - s;
        if (!out_ready) div_nrdy_n++;
      end
      if (acc && div) both_n++;
      if (err) err_n++;
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      if (done) begin
        done_n++;
        if (done_rel < 0) done_rel = cyc - s;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_stats();
    acc_n = 0; div_n = 0; both_n = 0; err_n = 0; done_n = 0;
    busy_n = 0; rdy_n = 0; div_nrdy_n = 0;
    first_acc = -1; last_acc = -1; first_div = -1; done_rel = -1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; out_ready = 1'b0; norm_wr_in = '0; start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one pass. iv_mode 0: in_valid always 1; 1: in_valid on odd rel cycles.
  // out_ready low for rel in [or_lo, or_lo+or_len). Two optional strobe
  // injections. rst_rel >= 0 asserts reset in that cycle and returns.
  task automatic run_pass(input int n, input int iv_mode, input int or_lo,
                          input int or_len, input int inj_rel_a, input logic [7:0] inj_a,
                          input int inj_rel_b, input logic [7:0] inj_b,
                          input int rst_rel, input int budget);
    int rel;
    clear_stats();
    num_rows   = 5'(n);
    start      = 1'b1;
    in_valid   = (iv_mode == 0);
    out_ready  = 1'b1;
    norm_wr_in = '0;
    s          = cyc;
    mon_on     = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rel = cyc - s;
      if (rel == rst_rel) begin
        mon_on = 1'b0;
        reset  = 1'b0;
        #1;
        return;
      end
      if (done_rel >= 0) break;
      in_valid   = (iv_mode == 0) ? 1'b1 : ((rel % 2) == 1);
      out_ready  = !((rel >= or_lo) && (rel < or_lo + or_len));
      norm_wr_in = last_div ? 8'hFF :
                   (rel == inj_rel_a) ? inj_a :
                   (rel == inj_rel_b) ? inj_b : 8'h00;
    end
    mon_on = 1'b0;
  endtask

  initial begin
    // Reset state, with inputs that would otherwise provoke activity.
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_acc", acc, 0);
    chk("rst_div", div, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    idle(2);

    // 1) N=4, no stalls.
    run_pass(4, 0, -1, 0, -1, 8'h00, -1, 8'h00, -1, 60);
    chk("t1_busy_after", busy, 0);
    chk("t1_first_acc", first_acc, 1);
    chk("t1_acc_n", acc_n, 4);
    chk("t1_last_acc", last_acc, 4);
    chk("t1_rdy_n", rdy_n, 4);
    chk("t1_first_div", first_div, 7);
    chk("t1_div_n", div_n, 4);
    chk("t1_overlap", both_n, 0);
    chk("t1_done_rel", done_rel, 12);
    chk("t1_done_n", done_n, 1);
    chk("t1_busy_n", busy_n, 12);
    chk("t1_err_n", err_n, 0);
    idle(3);

    // 2) N=16, in_valid toggling.
    run_pass(16, 1, -1, 0, -1, 8'h00, -1, 8'h00, -1, 120);
    chk("t2_acc_n", acc_n, 16);
    chk("t2_last_acc", last_acc, 31);
    chk("t2_rdy_n", rdy_n, 31);
    chk("t2_first_div", first_div, 34);
    chk("t2_div_n", div_n, 16);
    chk("t2_overlap", both_n, 0);
    chk("t2_done_rel", done_rel, 51);
    chk("t2_err_n", err_n, 0);
    idle(3);

    // 3) N=3, out_ready low for 5 cycles after the first div.
    run_pass(3, 0, 7, 5, -1, 8'h00, -1, 8'h00, -1, 60);
    chk("t3_first_div", first_div, 6);
    chk("t3_div_n", div_n, 3);
    chk("t3_div_no_ready", div_nrdy_n, 0);
    chk("t3_done_rel", done_rel, 15);
    chk("t3_err_n", err_n, 0);
    idle(3);

    // 4) Illegal num_rows: 0 then 17.
    run_pass(0, 0, -1, 0, -1, 8'h00, -1, 8'h00, -1, 4);
    chk("t4a_err_n", err_n, 1);
    chk("t4a_busy_n", busy_n, 0);
    chk("t4a_acc_n", acc_n, 0);
    idle(2);
    run_pass(17, 0, -1, 0, -1, 8'h00, -1, 8'h00, -1, 4);
    chk("t4b_err_n", err_n, 1);
    chk("t4b_busy_n", busy_n, 0);
    chk("t4b_acc_n", acc_n, 0);
    idle(3);

    // 5) N=4, partial strobe in ACC and full spurious strobe in DRAIN.
    run_pass(4, 0, -1, 0, 2, 8'h3C, 5, 8'hFF, -1, 60);
    chk("t5_err_n", err_n, 2);
    chk("t5_div_n", div_n, 4);
    chk("t5_done_rel", done_rel, 12);
    idle(3);

    // 6) N=8, reset after 3 divs, then a fresh N=2 pass.
    run_pass(8, 0, -1, 0, -1, 8'h00, -1, 8'h00, 14, 60);
    chk("t6_acc_n", acc_n, 8);
    chk("t6_div_n", div_n, 3);
    chk("t6_rst_outs", {26'd0, busy, in_ready, acc, div, done, err}, 0);
    idle(2);
    reset = 1'b1;
    idle(2);
    run_pass(2, 0, -1, 0, -1, 8'h00, -1, 8'h00, -1, 40);
    chk("t6_acc_n2", acc_n, 2);
    chk("t6_div_n2", div_n, 2);
    chk("t6_done_rel2", done_rel, 8);
    chk("t6_err_n2", err_n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_norm_seq_ctrl
`default_nettype wire
